// File: rtl/sram_arbiter.sv
// Two-requester round-robin arbiter with bounded burst lock in front of a
// single-port synchronous SRAM (1-cycle read latency).
module sram_arbiter #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam int unsigned      CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last, last_nxt;
  logic             win_vld, win_sel;

  // Winner: current owner keeps the port unless its burst is spent and the other side waits.
  always_comb begin
    win_vld = 1'b0;
    win_sel = 1'b0;
    if (state == OWN0 && m0_req && !(cnt == CNT_MAX && m1_req)) begin
      win_vld = 1'b1;
      win_sel = 1'b0;
    end else if (state == OWN1 && m1_req && !(cnt == CNT_MAX && m0_req)) begin
      win_vld = 1'b1;
      win_sel = 1'b1;
    end else if (m0_req && m1_req) begin
      win_vld = 1'b1;
      win_sel = ~last;
    end else if (m0_req) begin
      win_vld = 1'b1;
      win_sel = 1'b0;
    end else if (m1_req) begin
      win_vld = 1'b1;
      win_sel = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= 1'b1;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      last      <= last_nxt;
      m0_rvalid <= m0_gnt & ~m0_we;
      m1_rvalid <= m1_gnt & ~m1_we;
    end
  end

  // Burst count restarts at 1 on an ownership change or when the limit wraps uncontended.
  always_comb begin
    state_nxt = IDLE;
    cnt_nxt   = '0;
    last_nxt  = last;
    if (win_vld) begin
      state_nxt = win_sel ? OWN1 : OWN0;
      last_nxt  = win_sel;
      if (state == state_nxt && cnt < CNT_MAX) begin
        cnt_nxt = cnt + CNT_ONE;
      end else begin
        cnt_nxt = CNT_ONE;
      end
    end
  end

  // Grants are held off while reset is asserted so no SRAM access can slip through.
  always_comb begin
    m0_gnt     = reset_n & win_vld & ~win_sel;
    m1_gnt     = reset_n & win_vld & win_sel;
    sram_en    = m0_gnt | m1_gnt;
    sram_we    = (m0_gnt & m0_we) | (m1_gnt & m1_we);
    sram_addr  = '0;
    sram_wdata = '0;
    if (m0_gnt) begin
      sram_addr  = m0_addr;
      sram_wdata = m0_wdata;
    end else if (m1_gnt) begin
      sram_addr  = m1_addr;
      sram_wdata = m1_wdata;
    end
  end

  assign m0_rdata = sram_rdata;
  assign m1_rdata = sram_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM, shadow-memory read scoreboard,
// and per-scenario grant/reset checks.
module tb_sram_arbiter;

  logic        clk;
  logic        reset_n;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [5:0]  m0_addr;
  logic [23:0] m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [5:0]  m1_addr;
  logic [23:0] m1_wdata, m1_rdata;
  logic        sram_en, sram_we;
  logic [5:0]  sram_addr;
  logic [23:0] sram_wdata, sram_rdata;

  int total = 0;
  int bad   = 0;

  logic [23:0] mem    [64];
  logic [23:0] shadow [64];
  logic [23:0] q0 [$];
  logic [23:0] q1 [$];

  sram_arbiter #(.DATA_WIDTH(24), .ADDR_WIDTH(6), .MAX_BURST(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port SRAM with registered read output.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  // Scoreboard: read grants push the shadow value; rvalid one cycle later pops it.
  always @(negedge clk) begin
    logic [23:0] exp;
    if (!reset_n) begin
      q0.delete();
      q1.delete();
    end else begin
      if (m0_rvalid) begin
        total++;
        if (q0.size() == 0) begin
          bad++;
          $display("FAIL rvalid0_spurious: m0_rvalid=1 with no read outstanding");
        end else begin
          exp = q0.pop_front();
          if (m0_rdata !== exp) begin
            bad++;
            $display("FAIL rdata0: got %h expected %h", m0_rdata, exp);
          end
        end
      end else if (q0.size() != 0) begin
        total++;
        bad++;
        $display("FAIL rvalid0_missing: m0_rvalid=0 one cycle after read grant");
        q0.delete();
      end
      if (m1_rvalid) begin
        total++;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL rvalid1_spurious: m1_rvalid=1 with no read outstanding");
        end else begin
          exp = q1.pop_front();
          if (m1_rdata !== exp) begin
            bad++;
            $display("FAIL rdata1: got %h expected %h", m1_rdata, exp);
          end
        end
      end else if (q1.size() != 0) begin
        total++;
        bad++;
        $display("FAIL rvalid1_missing: m1_rvalid=0 one cycle after read grant");
        q1.delete();
      end
      if (m0_gnt) begin
        if (m0_we) shadow[m0_addr] = m0_wdata;
        else       q0.push_back(shadow[m0_addr]);
      end
      if (m1_gnt) begin
        if (m1_we) shadow[m1_addr] = m1_wdata;
        else       q1.push_back(shadow[m1_addr]);
      end
    end
  end

  task automatic idle(input int n);
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'd0; m0_wdata = 24'h111111;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'd1;
    repeat (2) begin
      @(negedge clk);
      total++;
      if ({m0_gnt, m1_gnt, sram_en, sram_we, m0_rvalid, m1_rvalid} !== 6'b0) begin
        bad++;
        $display("FAIL reset_hold: gnt0/gnt1/en/we/rv0/rv1=%b expected 000000",
                 {m0_gnt, m1_gnt, sram_en, sram_we, m0_rvalid, m1_rvalid});
      end
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      bad++;
      $display("FAIL reset_first_tie: gnt0/gnt1=%b expected 10", {m0_gnt, m1_gnt});
    end
    @(posedge clk); #1;
    m0_req = 1'b0;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL reset_second: gnt0/gnt1=%b expected 01", {m0_gnt, m1_gnt});
    end
    @(posedge clk); #1;
    idle(2);
  endtask

  task automatic test_write_read();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'd5; m0_wdata = 24'hABCDEF;
    @(negedge clk);
    total++;
    if ({m0_gnt, sram_en, sram_we, sram_addr, sram_wdata} !== {3'b111, 6'd5, 24'hABCDEF}) begin
      bad++;
      $display("FAIL wr_beat: gnt/en/we=%b addr=%0d wdata=%h expected 111 5 abcdef",
               {m0_gnt, sram_en, sram_we}, sram_addr, sram_wdata);
    end
    @(posedge clk); #1;
    m0_we = 1'b0;
    @(negedge clk);
    total++;
    if ({m0_gnt, sram_en, sram_we, sram_addr} !== {3'b110, 6'd5}) begin
      bad++;
      $display("FAIL rd_beat: gnt/en/we=%b addr=%0d expected 110 5",
               {m0_gnt, sram_en, sram_we}, sram_addr);
    end
    @(posedge clk); #1;
    m0_req = 1'b0;
    @(negedge clk);
    total++;
    if ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, 24'hABCDEF}) begin
      bad++;
      $display("FAIL rd_return: rv0/rv1=%b rdata=%h expected 10 abcdef",
               {m0_rvalid, m1_rvalid}, m0_rdata);
    end
    @(posedge clk); #1;
    idle(1);
  endtask

  task automatic test_preempt();
    int         exp_sel [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    logic [5:0] a0 = 6'd20;
    logic [5:0] a1 = 6'd30;
    logic [1:0] exp;
    logic       g0, g1;
    m0_we = 1'b0;
    m1_we = 1'b0;
    for (int c = 0; c < 9; c++) begin
      m0_req = 1'b1;
      m1_req = (c >= 1);
      m0_addr = a0;
      m1_addr = a1;
      exp = (exp_sel[c] != 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      total++;
      if ({m0_gnt, m1_gnt} !== exp) begin
        bad++;
        $display("FAIL preempt_c%0d: gnt0/gnt1=%b expected %b", c, {m0_gnt, m1_gnt}, exp);
      end
      g0 = m0_gnt;
      g1 = m1_gnt;
      @(posedge clk); #1;
      if (g0) a0 = a0 + 6'd1;
      if (g1) a1 = a1 + 6'd1;
    end
    idle(2);
  endtask

  task automatic test_long_burst();
    logic [23:0] d;
    m0_we = 1'b1;
    for (int i = 0; i < 10; i++) begin
      m0_req   = 1'b1;
      m0_addr  = 6'(40 + i);
      d        = 24'hA00000 + 24'(i);
      m0_wdata = d;
      @(negedge clk);
      total++;
      if ({m0_gnt, m1_gnt, sram_en, sram_we, sram_wdata} !== {4'b1011, d}) begin
        bad++;
        $display("FAIL long_burst_%0d: gnt0/gnt1/en/we=%b wdata=%h expected 1011 %h",
                 i, {m0_gnt, m1_gnt, sram_en, sram_we}, sram_wdata, d);
      end
      @(posedge clk); #1;
    end
    idle(1);
    m1_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m1_req  = 1'b1;
      m1_addr = 6'(40 + 4 * i + (i == 2 ? 1 : 0));
      @(negedge clk);
      total++;
      if ({m0_gnt, m1_gnt} !== 2'b01) begin
        bad++;
        $display("FAIL readback_%0d: gnt0/gnt1=%b expected 01", i, {m0_gnt, m1_gnt});
      end
      @(posedge clk); #1;
    end
    idle(2);
  endtask

  task automatic test_tie();
    m0_we = 1'b0; m1_we = 1'b0;
    m0_req = 1'b1; m0_addr = 6'd41;
    m1_req = 1'b1; m1_addr = 6'd42;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      bad++;
      $display("FAIL tie_after_m1: gnt0/gnt1=%b expected 10", {m0_gnt, m1_gnt});
    end
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt, sram_en} !== 3'b000) begin
      bad++;
      $display("FAIL tie_idle: gnt0/gnt1/en=%b expected 000", {m0_gnt, m1_gnt, sram_en});
    end
    @(posedge clk); #1;
    m0_req = 1'b1; m0_addr = 6'd43;
    m1_req = 1'b1; m1_addr = 6'd44;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL tie_after_m0: gnt0/gnt1=%b expected 01", {m0_gnt, m1_gnt});
    end
    @(posedge clk); #1;
    m1_req = 1'b0;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      bad++;
      $display("FAIL drop_release: gnt0/gnt1=%b expected 10", {m0_gnt, m1_gnt});
    end
    @(posedge clk); #1;
    idle(2);
  endtask

  task automatic test_reset_mid();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'd45;
    @(negedge clk);
    total++;
    if (m1_gnt !== 1'b1) begin
      bad++;
      $display("FAIL mid_rd_gnt: m1_gnt=%b expected 1", m1_gnt);
    end
    @(posedge clk); #1;
    m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'd45; m0_wdata = 24'h123456;
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if ({m1_rvalid, m0_gnt, sram_en, sram_we} !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset_async: rv1/gnt0/en/we=%b expected 0000",
               {m1_rvalid, m0_gnt, sram_en, sram_we});
    end
    m1_req = 1'b1; m1_addr = 6'd46;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt, sram_en} !== 3'b000) begin
      bad++;
      $display("FAIL mid_reset_hold: gnt0/gnt1/en=%b expected 000", {m0_gnt, m1_gnt, sram_en});
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    m0_we = 1'b0;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b1000) begin
      bad++;
      $display("FAIL mid_release: gnt0/gnt1/rv0/rv1=%b expected 1000",
               {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid});
    end
    @(posedge clk); #1;
    m0_req = 1'b0;
    @(negedge clk);
    total++;
    if ({m1_gnt, m0_rvalid, m0_rdata} !== {2'b11, 24'hA00005}) begin
      bad++;
      $display("FAIL mid_no_write: gnt1/rv0=%b rdata=%h expected 11 a00005",
               {m1_gnt, m0_rvalid}, m0_rdata);
    end
    @(posedge clk); #1;
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]    = 24'h0;
      shadow[i] = 24'h0;
    end
    sram_rdata = 24'h0;
    reset_n  = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    #2;
    reset_n = 1'b0;
    test_reset();
    test_write_read();
    test_preempt();
    test_long_burst();
    test_tie();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
